multi_counter: RTL and testbench

MULTI_COUNTER -- requirements
Module: multi_counter

---
 rtl/counter_pkg.sv | 20 ++
 rtl/multi_counter_if.sv | 36 +++
 rtl/chan_counter.sv | 61 ++++++
 rtl/multi_counter.sv | 53 +++++
 tb/tb_multi_counter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared defaults and reset constants for the multi-channel prescaled counter.
package counter_pkg;

  localparam int DEF_WIDTH    = 64;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_PRE_W    = 4;

  // Channel 1 comes out of reset counting every 4th event; all others every event.
  localparam int RST_DIV_CH1   = 3;
  localparam int RST_DIV_OTHER = 0;

  function automatic int sel_width(input int channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

  function automatic int reset_div(input int ch);
    return (ch == 1) ? RST_DIV_CH1 : RST_DIV_OTHER;
  endfunction

endpackage

// File: rtl/multi_counter_if.sv
// Control and status bundle between a counter master and the multi_counter block.
interface multi_counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int PRE_W    = DEF_PRE_W
) ();

  localparam int SEL_W = sel_width(CHANNELS);

  logic                      En;
  logic [SEL_W-1:0]          Slt;
  logic                      Load;
  logic [SEL_W-1:0]          LoadSel;
  logic [WIDTH-1:0]          LoadVal;
  logic                      CfgWe;
  logic [SEL_W-1:0]          CfgSel;
  logic [PRE_W-1:0]          CfgDiv;
  logic                      Sat;
  logic [CHANNELS-1:0]       OvfClr;
  logic [CHANNELS*WIDTH-1:0] Count;
  logic [CHANNELS-1:0]       Ovf;
  logic [CHANNELS-1:0]       Tick;

  modport master (
    output En, Slt, Load, LoadSel, LoadVal, CfgWe, CfgSel, CfgDiv, Sat, OvfClr,
    input  Count, Ovf, Tick
  );

  modport slave (
    input  En, Slt, Load, LoadSel, LoadVal, CfgWe, CfgSel, CfgDiv, Sat, OvfClr,
    output Count, Ovf, Tick
  );

endinterface

// File: rtl/chan_counter.sv
// One counter channel: prescaler, divisor, counter, sticky overflow and tick pulse.
module chan_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PRE_W   = DEF_PRE_W,
  parameter int RST_DIV = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Evt,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             CfgWe,
  input  logic [PRE_W-1:0] CfgDiv,
  input  logic             Sat,
  input  logic             OvfClr,
  output logic [WIDTH-1:0] Count,
  output logic             Ovf,
  output logic             Tick
);

  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] div;
  logic             step;
  logic             advance;
  logic             at_max;
  logic             bump;

  // NOTE: every signal gets a value on every pass through always_comb, so no latch is inferred.
  always_comb begin
    step    = Evt && !Load && !CfgWe;
    advance = step && (pre == div);
    at_max  = &Count;
    bump    = advance && !(at_max && Sat);
  end

  // NOTE: the divisor is state and must be reset too, otherwise channel 1 would not start at divide-by-4.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Count <= '0;
      pre   <= '0;
      div   <= PRE_W'(RST_DIV);
      Ovf   <= 1'b0;
      Tick  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      Tick <= bump;
      Ovf  <= (advance && at_max) || (Ovf && !OvfClr);

      if (Load)      Count <= LoadVal;
      else if (bump) Count <= Count + WIDTH'(1);

      if (Load || CfgWe) pre <= '0;
      else if (step)     pre <= advance ? '0 : pre + PRE_W'(1);

      if (CfgWe) div <= CfgDiv;
    end
  end

endmodule

// File: rtl/multi_counter.sv
// Multi-channel prescaled counter: decodes channel selects and gathers channel outputs.
module multi_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int PRE_W    = DEF_PRE_W
) (
  input  logic            Clk,
  input  logic            Reset,
  multi_counter_if.slave  bus
);

  localparam int SEL_W = sel_width(CHANNELS);

  logic [WIDTH-1:0] count_a [CHANNELS];
  logic             ovf_a   [CHANNELS];
  logic             tick_a  [CHANNELS];

  // Out-of-range selects match no channel and are therefore ignored.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    chan_counter #(
      .WIDTH   (WIDTH),
      .PRE_W   (PRE_W),
      .RST_DIV (reset_div(i))
    ) u_chan (
      .Clk     (Clk),
      .Reset   (Reset),
      .Evt     (bus.En && (bus.Slt == SEL_W'(i))),
      .Load    (bus.Load && (bus.LoadSel == SEL_W'(i))),
      .LoadVal (bus.LoadVal),
      .CfgWe   (bus.CfgWe && (bus.CfgSel == SEL_W'(i))),
      .CfgDiv  (bus.CfgDiv),
      .Sat     (bus.Sat),
      .OvfClr  (bus.OvfClr[i]),
      .Count   (count_a[i]),
      .Ovf     (ovf_a[i]),
      .Tick    (tick_a[i])
    );
  end

  always_comb begin
    bus.Count = '0;
    bus.Ovf   = '0;
    bus.Tick  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.Count[i*WIDTH +: WIDTH] = count_a[i];
      bus.Ovf[i]                  = ovf_a[i];
      bus.Tick[i]                 = tick_a[i];
    end
  end

endmodule

// File: tb/tb_multi_counter.sv
// Scoreboard bench for multi_counter: directed scenarios plus random traffic against an event-count model.
module tb_multi_counter;

  localparam int W    = 8;
  localparam int CH   = 3;
  localparam int PW   = 4;
  localparam int MAXV = (1 << W) - 1;

  typedef struct packed {
    logic [CH*W-1:0] cnt;
    logic [CH-1:0]   ovf;
    logic [CH-1:0]   tick;
  } exp_t;

  logic Clk;
  logic Reset;

  multi_counter_if #(.WIDTH(W), .CHANNELS(CH), .PRE_W(PW)) bus ();

  multi_counter #(.WIDTH(W), .CHANNELS(CH), .PRE_W(PW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;
  exp_t exp_q[$];

  // Reference state: counts, events accumulated toward the next advance, divisors, sticky flags.
  int unsigned m_cnt [CH];
  int unsigned m_acc [CH];
  int unsigned m_div [CH];
  bit [CH-1:0] m_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] cnt_of(input int i);
    return bus.Count[i*W +: W];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0;
      m_acc[i] = 0;
      m_div[i] = (i == 1) ? 3 : 0;
    end
    m_ovf = '0;
  endtask

  task automatic idle();
    bus.En = 0; bus.Slt = 0; bus.Load = 0; bus.LoadSel = 0; bus.LoadVal = 0;
    bus.CfgWe = 0; bus.CfgSel = 0; bus.CfgDiv = 0; bus.Sat = 0; bus.OvfClr = 0;
  endtask

  // One clock: apply the rules to the inputs present at the edge and queue the expected outputs.
  task automatic step();
    exp_t e;
    bit [CH-1:0] tick;
    @(posedge Clk);
    tick = '0;
    for (int i = 0; i < CH; i++) begin
      bit ld, cf, ev, ovf_set;
      ld = bus.Load  && (int'(bus.LoadSel) == i);
      cf = bus.CfgWe && (int'(bus.CfgSel) == i);
      ev = bus.En && (int'(bus.Slt) == i) && !ld && !cf;
      ovf_set = 0;
      if (ev) begin
        m_acc[i]++;
        if (m_acc[i] == m_div[i] + 1) begin
          m_acc[i] = 0;
          if (m_cnt[i] == MAXV) begin
            ovf_set = 1;
            if (!bus.Sat) begin
              m_cnt[i] = 0;
              tick[i]  = 1;
            end
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
            tick[i]  = 1;
          end
        end
      end
      if (ld) begin m_cnt[i] = bus.LoadVal; m_acc[i] = 0; end
      if (cf) begin m_div[i] = bus.CfgDiv;  m_acc[i] = 0; end
      m_ovf[i] = ovf_set || (m_ovf[i] && !bus.OvfClr[i]);
    end
    for (int i = 0; i < CH; i++) e.cnt[i*W +: W] = W'(m_cnt[i]);
    e.ovf  = m_ovf;
    e.tick = tick;
    exp_q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < CH; i++) check($sformatf("%s_count%0d", tag, i), 64'(cnt_of(i)), 64'd0);
    check({tag, "_ovf"},  64'(bus.Ovf),  64'd0);
    check({tag, "_tick"}, 64'(bus.Tick), 64'd0);
  endtask

  // Called at a falling edge: pulse reset between edges and look at outputs while it is high.
  task automatic reset_pulse(input string tag);
    #2 Reset = 1'b1;
    #1 check_all_zero(tag);
    model_reset();
    #1 Reset = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int i = 0; i < CH; i++)
        check($sformatf("sb_count%0d", i), 64'(cnt_of(i)), 64'(e.cnt[i*W +: W]));
      check("sb_ovf",  64'(bus.Ovf),  64'(e.ovf));
      check("sb_tick", 64'(bus.Tick), 64'(e.tick));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    Reset = 1'b1;
    model_reset();
    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b0;

    // Channel 0 divides by 1: ten events, ten ticks.
    bus.En = 1; bus.Slt = 0;
    repeat (10) step();
    check("ch0_ten_events", 64'(cnt_of(0)), 64'd10);

    // Channel 1 resets to divide-by-4.
    idle();
    reset_pulse("reset2");
    bus.En = 1; bus.Slt = 1;
    repeat (8) step();
    check("ch1_eight_events", 64'(cnt_of(1)), 64'd2);

    // Wrap versus saturate at all-ones on channel 2.
    idle(); bus.Load = 1; bus.LoadSel = 2; bus.LoadVal = 8'hFF; step();
    idle(); bus.En = 1; bus.Slt = 2; bus.Sat = 0; step();
    check("ch2_wrap_count", 64'(cnt_of(2)), 64'h00);
    check("ch2_wrap_ovf",   64'(bus.Ovf[2]), 64'd1);
    idle(); bus.OvfClr = 3'b100; step();
    idle(); bus.Load = 1; bus.LoadSel = 2; bus.LoadVal = 8'hFF; step();
    idle(); bus.En = 1; bus.Slt = 2; bus.Sat = 1; step();
    check("ch2_sat_count", 64'(cnt_of(2)), 64'hFF);
    check("ch2_sat_tick",  64'(bus.Tick[2]), 64'd0);

    // Overflow beats a same-cycle clear; a lone clear then takes effect.
    idle(); bus.Load = 1; bus.LoadSel = 2; bus.LoadVal = 8'hFF; bus.OvfClr = 3'b100; step();
    idle(); bus.En = 1; bus.Slt = 2; bus.OvfClr = 3'b100; step();
    check("ovf_set_beats_clr", 64'(bus.Ovf[2]), 64'd1);
    idle(); bus.OvfClr = 3'b100; step();
    check("ovf_clr_alone", 64'(bus.Ovf[2]), 64'd0);

    // Divisor rewrite on channel 0 after one event.
    idle(); bus.Load = 1; bus.LoadSel = 0; bus.LoadVal = 0; step();
    idle(); bus.En = 1; bus.Slt = 0; step();
    idle(); bus.CfgWe = 1; bus.CfgSel = 0; bus.CfgDiv = 2; step();
    idle(); bus.En = 1; bus.Slt = 0;
    repeat (6) step();
    check("ch0_div2", 64'(cnt_of(0)), 64'd3);

    // Partial prescale on channel 1 is lost across an asynchronous reset.
    idle();
    reset_pulse("reset3");
    bus.En = 1; bus.Slt = 1;
    repeat (3) step();
    idle();
    reset_pulse("reset_mid");
    bus.En = 1; bus.Slt = 1;
    repeat (4) step();
    check("ch1_after_reset", 64'(cnt_of(1)), 64'd1);

    // Load and CfgWe on one channel together, blocking an event there.
    idle(); bus.Load = 1; bus.LoadSel = 1; bus.LoadVal = 5; bus.CfgWe = 1; bus.CfgSel = 1;
    bus.CfgDiv = 1; bus.En = 1; bus.Slt = 1; step();
    check("ld_cfg_same", 64'(cnt_of(1)), 64'd5);
    idle(); bus.En = 1; bus.Slt = 1; repeat (2) step();
    check("ld_cfg_same_div", 64'(cnt_of(1)), 64'd6);

    // Load, CfgWe and an event on three different channels; then out-of-range selects.
    idle(); bus.Load = 1; bus.LoadSel = 0; bus.LoadVal = 8'h40; bus.CfgWe = 1; bus.CfgSel = 1;
    bus.CfgDiv = 0; bus.En = 1; bus.Slt = 2; step();
    idle(); bus.Load = 1; bus.LoadSel = 3; bus.LoadVal = 8'h77; bus.CfgWe = 1; bus.CfgSel = 3;
    bus.CfgDiv = 9; bus.En = 1; bus.Slt = 3; step();
    idle(); step();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      bus.En      = ($urandom_range(0, 3) != 0);
      bus.Slt     = 2'($urandom_range(0, 3));
      bus.Load    = ($urandom_range(0, 9) == 0);
      bus.LoadSel = 2'($urandom_range(0, 3));
      bus.LoadVal = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      bus.CfgWe   = ($urandom_range(0, 11) == 0);
      bus.CfgSel  = 2'($urandom_range(0, 3));
      bus.CfgDiv  = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) bus.Sat = ~bus.Sat;
      bus.OvfClr  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      step();
    end
    idle();

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge Clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
